led_ctrl: RTL and testbench

Serial driver for four daisy-chained LED shift-register lanes. On a start command it reads a 128-word × 16-bit column buffer, shifts the words out MSB-first on four parallel data lines with a shared shift clock, then pulses the latch and reports completion. It sits between the column-buffer RAM and the LED driver chips and is clocked by the SPI clock domain.

---
 rtl/led_ctrl.sv | 132 +++++++++++++
 tb/tb_led_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
// Serial driver for four daisy-chained LED shift-register lanes: fetches 32 groups of
// four 16-bit words from the column buffer and shifts them out MSB-first, then latches.
module led_ctrl (
  input  logic        spiClk,
  input  logic        nReset,
  input  logic        cmdStart,
  input  logic [15:0] ledColBuf,
  output logic [6:0]  rdaddress,
  output logic        cmdDone,
  output logic        busy,
  output logic [3:0]  SDOs,
  output logic        LAT,
  output logic        SCLK
);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DONE} state_t;

  state_t           state, state_n;
  logic [4:0]       cnt, cnt_n;
  logic [4:0]       group, group_n;
  logic [4:0]       nxt;
  logic [3:0]       bitsel;
  logic [3:0][15:0] word, word_n;
  logic             startprev;
  logic             start;
  logic [6:0]       rdaddress_n;
  logic [3:0]       sdos_n;
  logic             sclk_n, lat_n, done_n, busy_n;

  assign start  = cmdStart & ~startprev;
  assign nxt    = cnt + 5'd1;
  // Two SHIFT cycles per bit, MSB first: bit index is 15 minus the bit-pair count.
  assign bitsel = ~nxt[4:1];

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      state     <= IDLE;
      cnt       <= '0;
      group     <= '0;
      word      <= '0;
      startprev <= 1'b0;
      rdaddress <= '0;
      SDOs      <= '0;
      SCLK      <= 1'b0;
      LAT       <= 1'b0;
      cmdDone   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      group     <= group_n;
      word      <= word_n;
      startprev <= cmdStart;
      rdaddress <= rdaddress_n;
      SDOs      <= sdos_n;
      SCLK      <= sclk_n;
      LAT       <= lat_n;
      cmdDone   <= done_n;
      busy      <= busy_n;
    end
  end

  // Outputs are registered, so they are derived here from the state being entered.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    group_n     = group;
    word_n      = word;
    rdaddress_n = rdaddress;
    sdos_n      = '0;
    sclk_n      = 1'b0;
    lat_n       = 1'b0;
    done_n      = 1'b0;
    busy_n      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = FETCH;
          cnt_n       = '0;
          group_n     = '0;
          rdaddress_n = '0;
          busy_n      = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      FETCH: begin
        busy_n = 1'b1;
        // Capturing on the second address cycle covers 0- or 1-cycle read latency.
        if (cnt[0])
          word_n[cnt[2:1]] = ledColBuf;
        if (cnt == 5'd7) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sdos_n  = {word_n[3][15], word_n[2][15], word_n[1][15], word_n[0][15]};
        end else begin
          cnt_n       = nxt;
          rdaddress_n = {group, nxt[2:1]};
        end
      end

      SHIFT: begin
        busy_n = 1'b1;
        if (cnt == 5'd31) begin
          cnt_n = '0;
          if (group == 5'd31) begin
            state_n = LATCH;
            lat_n   = 1'b1;
          end else begin
            state_n     = FETCH;
            group_n     = group + 5'd1;
            rdaddress_n = {group_n, 2'b00};
          end
        end else begin
          cnt_n  = nxt;
          sclk_n = nxt[0];
          sdos_n = {word[3][bitsel], word[2][bitsel], word[1][bitsel], word[0][bitsel]};
        end
      end

      LATCH: begin
        state_n = DONE;
        done_n  = 1'b1;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: per-cycle comparison against a timing model derived
// from the frame schedule, with combinational and registered column-buffer models.
module tb_led_ctrl;

  logic        spiClk = 1'b0;
  logic        nReset = 1'b0;
  logic        cmdStart = 1'b0;
  logic [15:0] ledColBuf;
  logic [6:0]  rdaddress;
  logic        cmdDone, busy, LAT, SCLK;
  logic [3:0]  SDOs;

  logic [15:0] mem [128];
  logic        regMode = 1'b0;
  logic [15:0] ramQ = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 spiClk = ~spiClk;

  // Column buffer: either combinational read or one-cycle registered read.
  always @(posedge spiClk) ramQ <= mem[rdaddress];
  assign ledColBuf = regMode ? ramQ : mem[rdaddress];

  led_ctrl dut (
    .spiClk    (spiClk),
    .nReset    (nReset),
    .cmdStart  (cmdStart),
    .ledColBuf (ledColBuf),
    .rdaddress (rdaddress),
    .cmdDone   (cmdDone),
    .busy      (busy),
    .SDOs      (SDOs),
    .LAT       (LAT),
    .SCLK      (SCLK)
  );

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for cycle c of a frame (cycle 0 = start edge sampled).
  task automatic modelAt(input int c, output logic [6:0] ra, output logic [3:0] sd,
                         output logic sc, output logic la, output logic dn, output logic bz);
    int g, o, s, b;
    logic [15:0] w;
    ra = 7'd127; sd = '0; sc = 1'b0; la = 1'b0; dn = 1'b0; bz = 1'b0;
    if (c >= 1 && c <= 1280) begin
      bz = 1'b1;
      g  = (c - 1) / 40;
      o  = (c - 1) % 40;
      if (o < 8) begin
        ra = 7'(4 * g + o / 2);
      end else begin
        ra = 7'(4 * g + 3);
        s  = o - 8;
        b  = 15 - s / 2;
        sc = (s % 2 == 1);
        for (int l = 0; l < 4; l++) begin
          w = mem[4 * g + l];
          sd[l] = w[b];
        end
      end
    end else if (c == 1281) begin
      bz = 1'b1;
      la = 1'b1;
    end else if (c == 1282) begin
      dn = 1'b1;
    end
  endtask

  task automatic checkCycle(input int c);
    logic [6:0] ra;
    logic [3:0] sd;
    logic sc, la, dn, bz;
    modelAt(c, ra, sd, sc, la, dn, bz);
    checkOutput("rdaddress", c, 32'(rdaddress), 32'(ra));
    checkOutput("SDOs", c, 32'(SDOs), 32'(sd));
    checkOutput("SCLK", c, 32'(SCLK), 32'(sc));
    checkOutput("LAT", c, 32'(LAT), 32'(la));
    checkOutput("cmdDone", c, 32'(cmdDone), 32'(dn));
    checkOutput("busy", c, 32'(busy), 32'(bz));
  endtask

  task automatic applyStimulus();
    @(negedge spiClk);
    cmdStart = 1'b1;
  endtask

  task automatic runFrame(input int holdCycles, input int p1, input int p2, input bit chain,
                          input int abortAt);
    int lastC;
    int sclkEdges, latCnt, doneCnt, busyCnt, holdViol;
    logic prevSclk;
    logic [3:0] prevSdos;
    sclkEdges = 0; latCnt = 0; doneCnt = 0; busyCnt = 0; holdViol = 0;
    prevSclk = 1'b0; prevSdos = '0;
    lastC = (abortAt > 0) ? abortAt : 1282;
    for (int c = 1; c <= lastC; c++) begin
      @(negedge spiClk);
      checkCycle(c);
      if (SCLK && !prevSclk) sclkEdges++;
      if (SCLK && SDOs !== prevSdos) holdViol++;
      if (LAT) latCnt++;
      if (cmdDone) doneCnt++;
      if (busy) busyCnt++;
      prevSclk = SCLK;
      prevSdos = SDOs;
      cmdStart = (c < holdCycles) || (c == p1) || (c == p2) || (chain && c == 1282);
      if (c == abortAt) nReset = 1'b0;
    end
    if (abortAt == 0) begin
      checkOutput("sclkEdges", lastC, 32'(sclkEdges), 32'd512);
      checkOutput("latCount", lastC, 32'(latCnt), 32'd1);
      checkOutput("doneCount", lastC, 32'(doneCnt), 32'd1);
      checkOutput("busyCycles", lastC, 32'(busyCnt), 32'd1281);
      checkOutput("sdosChangeWhileSclk", lastC, 32'(holdViol), 32'd0);
    end else begin
      checkOutput("abortLat", lastC, 32'(latCnt), 32'd0);
      checkOutput("abortDone", lastC, 32'(doneCnt), 32'd0);
    end
  endtask

  task automatic idleCycles(input int n, input logic [6:0] ra);
    for (int i = 0; i < n; i++) begin
      @(negedge spiClk);
      checkOutput("idle_busy", i, 32'(busy), 32'd0);
      checkOutput("idle_cmdDone", i, 32'(cmdDone), 32'd0);
      checkOutput("idle_LAT", i, 32'(LAT), 32'd0);
      checkOutput("idle_SCLK", i, 32'(SCLK), 32'd0);
      checkOutput("idle_SDOs", i, 32'(SDOs), 32'd0);
      checkOutput("idle_rdaddress", i, 32'(rdaddress), 32'(ra));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdaddress"}, 0, 32'(rdaddress), 32'd0);
    checkOutput({tag, "_SDOs"}, 0, 32'(SDOs), 32'd0);
    checkOutput({tag, "_SCLK"}, 0, 32'(SCLK), 32'd0);
    checkOutput({tag, "_LAT"}, 0, 32'(LAT), 32'd0);
    checkOutput({tag, "_cmdDone"}, 0, 32'(cmdDone), 32'd0);
    checkOutput({tag, "_busy"}, 0, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'(i);
    regMode = 1'b0;

    // Reset state.
    repeat (3) @(negedge spiClk);
    checkAllZero("reset");
    nReset = 1'b1;
    idleCycles(2, 7'd0);

    // Start level held for 6 cycles, combinational buffer with word = address.
    $display("[TB] frame 1: held start, ledColBuf = rdaddress");
    applyStimulus();
    runFrame(6, 0, 0, 1'b0, 0);
    idleCycles(10, 7'd127);

    // Registered buffer, constant pattern.
    $display("[TB] frame 2: registered buffer, all words 0xA5C3");
    regMode = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'hA5C3;
    applyStimulus();
    runFrame(1, 0, 0, 1'b0, 0);
    idleCycles(3, 7'd127);

    // Random buffer contents, start held high past completion.
    $display("[TB] frame 3: random data, start held high throughout");
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    applyStimulus();
    runFrame(2000, 0, 0, 1'b0, 0);
    idleCycles(10, 7'd127);
    cmdStart = 1'b0;

    // Ignored mid-frame pulses, then a back-to-back frame from the DONE cycle.
    $display("[TB] frames 4-5: mid-frame pulses ignored, chained start in DONE");
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    applyStimulus();
    runFrame(1, 100, 600, 1'b1, 0);
    runFrame(1, 0, 0, 1'b0, 0);
    idleCycles(5, 7'd127);

    // Reset mid-frame, then a clean frame.
    $display("[TB] frame 6: reset at cycle 700, then full frame");
    applyStimulus();
    runFrame(1, 0, 0, 1'b0, 700);
    @(negedge spiClk);
    checkAllZero("abort");
    nReset = 1'b1;
    idleCycles(5, 7'd0);
    regMode = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    applyStimulus();
    runFrame(1, 0, 0, 1'b0, 0);
    idleCycles(3, 7'd127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
